alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Initiator/driver side of the 4-bit ALU operand/select/flag interface.
- Accepts ALU commands over a valid/ready command port and drives operands and select into an external combinational 4-bit ALU.
- Holds the operands stable for a programmable settle window, samples the result and flags, and returns them with the command tag over a valid/ready response port.
- Sits between a controller/test sequencer and the ALU datapath. Also rejects illegal opcodes and keeps a completed-operation count.

Parameters:
- SETTLE_CYCLES, 1, cycles the ALU inputs are held before sampling; legal range 1..15.
- TAG_W, 4, width of the command/response tag.
- CNT_W, 8, width of the completed-operation counter; wraps.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  operation code: 000 add, 001 sub, 010 and, 011 or, 100 xor; 101..111 illegal.
- cmd_a  input  4  operand A.
- cmd_b  input  4  operand B.
- cmd_tag  input  TAG_W  opaque tag, echoed back on the response.
- alu_a  output  4  registered operand A to the ALU.
- alu_b  output  4  registered operand B to the ALU.
- alu_sel  output  3  registered select to the ALU.
- alu_result  input  4  ALU result.
- alu_zero  input  1  ALU zero flag.
- alu_carry  input  1  ALU carry flag.
- alu_overflow  input  1  ALU overflow flag.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  4  sampled result.
- rsp_zero  output  1  sampled zero flag.
- rsp_carry  output  1  sampled carry flag.
- rsp_overflow  output  1  sampled overflow flag.
- rsp_illegal  output  1  command rejected as an illegal opcode.
- rsp_tag  output  TAG_W  tag of the command being answered.
- op_count  output  CNT_W  number of responses completed (handshaked).

Behaviour:
- FSM states: IDLE, DRIVE, RESP. cmd_ready = (state==IDLE). rsp_valid = (state==RESP).
- Reset values: state IDLE; alu_a, alu_b, alu_sel = 0; all rsp_* = 0; op_count = 0; settle counter = 0.
- Command accept occurs at an edge where cmd_valid && cmd_ready. On that edge, cmd_tag is latched to rsp_tag.
- Legal opcode at accept:
  - Load alu_a, alu_b and alu_sel from the command and clear rsp_illegal.
  - Load the settle counter with SETTLE_CYCLES-1 and go to DRIVE.
- Illegal opcode (>=101) at accept:
  - alu_* keep their previous values.
  - rsp_result = 0 and all rsp flags = 0; rsp_illegal = 1.
  - Go straight to RESP; rsp_valid rises one cycle after accept.
- DRIVE:
  - alu_* are held constant.
  - If the counter is nonzero, decrement it.
  - If it is zero, sample alu_result, alu_zero, alu_carry and alu_overflow into the rsp_* registers and go to RESP.
- Latency, accept to rsp_valid, legal opcode: SETTLE_CYCLES+1 cycles (2 at default).
- RESP:
  - rsp_* are held stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready: increment op_count (wraps at 2^CNT_W-1 → 0) and go to IDLE.
- No overlap: a new command is never accepted in the cycle its predecessor's response completes; cmd_ready rises the cycle after. Throughput is one op per SETTLE_CYCLES+2 cycles minimum.
- alu_* are only ever written at a legal accept, so the ALU inputs never change during DRIVE or RESP and never glitch between commands.
- Illegal responses also increment op_count.
- cmd_* values are ignored outside IDLE; cmd_valid may stay high indefinitely.
- Reset mid-operation (any state): synchronous return to the reset values. An in-flight command is dropped and produces no response.
- The flag values are those the ALU presents; the sequencer performs no recomputation.

Test Plan:
- SETTLE_CYCLES=1, ideal ALU model, cmd add a=3 b=4 tag=5, rsp_ready=1 → rsp_valid 2 cycles after accept; rsp_result=7, rsp_zero=0, rsp_tag=5, rsp_illegal=0; op_count 0→1.
- cmd sub a=5 b=5 → rsp_result=0, rsp_zero=1. Then cmd xor a=A b=F → rsp_result=5, rsp_zero=0. alu_sel reads 001 then 100, and each value is stable for the whole DRIVE window.
- Illegal op 110 a=9 b=9 tag=3 → rsp_valid 1 cycle after accept, rsp_illegal=1, rsp_result=0, rsp_tag=3; alu_a/alu_b/alu_sel unchanged from the previous command.
- Backpressure: and a=C b=A with rsp_ready=0 for 5 cycles → rsp_valid held, rsp_result=8 stable, cmd_ready=0 throughout. Release rsp_ready → op_count increments once and cmd_ready=1 the next cycle.
- SETTLE_CYCLES=4, or a=1 b=2 → rsp_valid exactly 5 cycles after accept, rsp_result=3. Perturbing the ALU model output in DRIVE cycles 1-3 must not affect the sampled value.
- rst asserted in DRIVE → next cycle state IDLE, all outputs 0, no response. Separately, 256 handshaked ops with CNT_W=8 → op_count wraps to 0.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response handshake bundle between a controller (master) and the
// ALU command sequencer (slave).
interface alu_cmd_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_result;
  logic             rsp_zero;
  logic             rsp_carry;
  logic             rsp_overflow;
  logic             rsp_illegal;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry,
           rsp_overflow, rsp_illegal, rsp_tag
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry,
           rsp_overflow, rsp_illegal, rsp_tag
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Drives a combinational 4-bit ALU: accepts one command, holds the ALU inputs for
// a settle window, samples result/flags and returns them with the command tag.
module alu_cmd_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int TAG_W         = 4,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_cmd_sequencer_if.slave bus,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic [2:0]         alu_sel,
  input  logic [3:0]         alu_result,
  input  logic               alu_zero,
  input  logic               alu_carry,
  input  logic               alu_overflow,
  output logic [CNT_W-1:0]   op_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [2:0] OP_LAST_LEGAL = 3'd4;
  localparam logic [3:0] SETTLE_LOAD   = 4'(SETTLE_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [3:0]       settle_reg, settle_next;
  logic [3:0]       alu_a_reg, alu_a_next;
  logic [3:0]       alu_b_reg, alu_b_next;
  logic [2:0]       alu_sel_reg, alu_sel_next;
  logic [3:0]       result_reg, result_next;
  logic             zero_reg, zero_next;
  logic             carry_reg, carry_next;
  logic             overflow_reg, overflow_next;
  logic             illegal_reg, illegal_next;
  logic [TAG_W-1:0] tag_reg, tag_next;
  logic [CNT_W-1:0] count_reg, count_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      settle_reg   <= '0;
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      alu_sel_reg  <= '0;
      result_reg   <= '0;
      zero_reg     <= 1'b0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      illegal_reg  <= 1'b0;
      tag_reg      <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      settle_reg   <= settle_next;
      alu_a_reg    <= alu_a_next;
      alu_b_reg    <= alu_b_next;
      alu_sel_reg  <= alu_sel_next;
      result_reg   <= result_next;
      zero_reg     <= zero_next;
      carry_reg    <= carry_next;
      overflow_reg <= overflow_next;
      illegal_reg  <= illegal_next;
      tag_reg      <= tag_next;
      count_reg    <= count_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    settle_next   = settle_reg;
    alu_a_next    = alu_a_reg;
    alu_b_next    = alu_b_reg;
    alu_sel_next  = alu_sel_reg;
    result_next   = result_reg;
    zero_next     = zero_reg;
    carry_next    = carry_reg;
    overflow_next = overflow_reg;
    illegal_next  = illegal_reg;
    tag_next      = tag_reg;
    count_next    = count_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          tag_next = bus.cmd_tag;
          if (bus.cmd_op <= OP_LAST_LEGAL) begin
            alu_a_next   = bus.cmd_a;
            alu_b_next   = bus.cmd_b;
            alu_sel_next = bus.cmd_op;
            illegal_next = 1'b0;
            settle_next  = SETTLE_LOAD;
            state_next   = ST_DRIVE;
          end else begin
            // ALU inputs are left untouched so the datapath never sees a rejected op.
            result_next   = '0;
            zero_next     = 1'b0;
            carry_next    = 1'b0;
            overflow_next = 1'b0;
            illegal_next  = 1'b1;
            state_next    = ST_RESP;
          end
        end
      end
      ST_DRIVE: begin
        if (settle_reg != 4'd0) begin
          settle_next = settle_reg - 4'd1;
        end else begin
          result_next   = alu_result;
          zero_next     = alu_zero;
          carry_next    = alu_carry;
          overflow_next = alu_overflow;
          state_next    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          count_next = count_reg + 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.cmd_ready    = (state_reg == ST_IDLE);
  assign bus.rsp_valid    = (state_reg == ST_RESP);
  assign bus.rsp_result   = result_reg;
  assign bus.rsp_zero     = zero_reg;
  assign bus.rsp_carry    = carry_reg;
  assign bus.rsp_overflow = overflow_reg;
  assign bus.rsp_illegal  = illegal_reg;
  assign bus.rsp_tag      = tag_reg;

  assign alu_a    = alu_a_reg;
  assign alu_b    = alu_b_reg;
  assign alu_sel  = alu_sel_reg;
  assign op_count = count_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench: two sequencers (settle 1 and settle 4) driving a behavioural ALU;
// expected responses are queued at issue time and popped by per-DUT monitors.
module tb_alu_cmd_sequencer;
  localparam int TAG_W = 4;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [3:0]       result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.TAG_W(TAG_W)) bus1 ();
  alu_cmd_sequencer_if #(.TAG_W(TAG_W)) bus2 ();

  logic [3:0]       a1, b1, res1, a2, b2, res2;
  logic [2:0]       sel1, sel2;
  logic             z1, c1, v1, z2, c2, v2;
  logic [CNT_W-1:0] cnt1, cnt2;
  logic             perturb2;

  alu_cmd_sequencer #(.SETTLE_CYCLES(1), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .alu_a(a1), .alu_b(b1), .alu_sel(sel1),
    .alu_result(res1), .alu_zero(z1), .alu_carry(c1), .alu_overflow(v1),
    .op_count(cnt1)
  );

  alu_cmd_sequencer #(.SETTLE_CYCLES(4), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .alu_a(a2), .alu_b(b2), .alu_sel(sel2),
    .alu_result(res2), .alu_zero(z2), .alu_carry(c2), .alu_overflow(v2),
    .op_count(cnt2)
  );

  // Behavioural ALU: {result, zero, carry, overflow}; carry is the borrow on sub.
  function automatic logic [6:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] sel);
    logic [4:0] w;
    logic [3:0] r;
    logic       c, v;
    w = 5'd0; r = 4'd0; c = 1'b0; v = 1'b0;
    case (sel)
      3'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[3:0]; c = w[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      3'd1: begin
        w = {1'b0, a} - {1'b0, b};
        r = w[3:0]; c = w[4];
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: r = 4'd0;
    endcase
    return {r, (r == 4'd0), c, v};
  endfunction

  always_comb begin
    {res1, z1, c1, v1} = alu_model(a1, b1, sel1);
    {res2, z2, c2, v2} = alu_model(a2, b2, sel2) ^ (perturb2 ? 7'h7F : 7'h00);
  end

  int   checks = 0;
  int   errors = 0;
  rsp_t q1[$];
  rsp_t q2[$];
  logic [CNT_W-1:0] exp_cnt1;
  logic [3:0] prev_a, prev_b;
  logic [2:0] prev_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon1
    rsp_t got, exp;
    if (!rst && bus1.rsp_valid && bus1.rsp_ready) begin
      got = {bus1.rsp_result, bus1.rsp_zero, bus1.rsp_carry, bus1.rsp_overflow,
             bus1.rsp_illegal, bus1.rsp_tag};
      if (q1.size() == 0) begin
        chk("rsp1_unexpected", 32'(got), 32'hFFFF_FFFF);
      end else begin
        exp = q1.pop_front();
        chk("rsp1", 32'(got), 32'(exp));
        $display("dut1 rsp tag=%0h result=%0h z=%0b c=%0b v=%0b ill=%0b",
                 got.tag, got.result, got.zero, got.carry, got.overflow, got.illegal);
      end
    end
  end

  always @(negedge clk) begin : mon2
    rsp_t got, exp;
    if (!rst && bus2.rsp_valid && bus2.rsp_ready) begin
      got = {bus2.rsp_result, bus2.rsp_zero, bus2.rsp_carry, bus2.rsp_overflow,
             bus2.rsp_illegal, bus2.rsp_tag};
      if (q2.size() == 0) begin
        chk("rsp2_unexpected", 32'(got), 32'hFFFF_FFFF);
      end else begin
        exp = q2.pop_front();
        chk("rsp2", 32'(got), 32'(exp));
        $display("dut2 rsp tag=%0h result=%0h z=%0b c=%0b v=%0b ill=%0b",
                 got.tag, got.result, got.zero, got.carry, got.overflow, got.illegal);
      end
    end
  end

  // Issue one command to dut1, check ALU-input stability and latency, and
  // (if rsp_ready is high) wait for completion and check op_count.
  task automatic issue1(input string nm, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [TAG_W-1:0] tag,
                        input rsp_t e, input int exp_lat);
    int guard;
    int lat;
    logic [3:0] ea, eb;
    logic [2:0] esel;
    q1.push_back(e);
    if (e.illegal) begin
      ea = prev_a; eb = prev_b; esel = prev_sel;
    end else begin
      ea = a; eb = b; esel = op;
    end
    bus1.cmd_valid = 1'b1; bus1.cmd_op = op; bus1.cmd_a = a; bus1.cmd_b = b; bus1.cmd_tag = tag;
    guard = 0;
    while (!bus1.cmd_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (!bus1.cmd_ready) begin
      chk({nm, "_ready_timeout"}, 32'(bus1.cmd_ready), 32'd1);
      bus1.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus1.cmd_valid = 1'b0; bus1.cmd_a = ~a; bus1.cmd_b = ~b; bus1.cmd_op = 3'd7;
    lat = 1;
    while (!bus1.rsp_valid && lat < 50) begin
      chk({nm, "_drive_alu"}, {21'd0, a1, b1, sel1}, {21'd0, ea, eb, esel});
      @(posedge clk); #1; lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_resp_alu"}, {21'd0, a1, b1, sel1}, {21'd0, ea, eb, esel});
    prev_a = ea; prev_b = eb; prev_sel = esel;
    if (bus1.rsp_ready) begin
      guard = 0;
      while (bus1.rsp_valid && guard < 50) begin
        @(posedge clk); #1; guard++;
      end
      exp_cnt1 = exp_cnt1 + 1'b1;
      chk({nm, "_op_count"}, 32'(cnt1), 32'(exp_cnt1));
      chk({nm, "_ready_after"}, 32'(bus1.cmd_ready), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    int lat;
    rst = 1'b1; perturb2 = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_op = '0; bus1.cmd_a = '0; bus1.cmd_b = '0;
    bus1.cmd_tag = '0; bus1.rsp_ready = 1'b1;
    bus2.cmd_valid = 1'b0; bus2.cmd_op = '0; bus2.cmd_a = '0; bus2.cmd_b = '0;
    bus2.cmd_tag = '0; bus2.rsp_ready = 1'b1;
    exp_cnt1 = '0; prev_a = '0; prev_b = '0; prev_sel = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("reset_cmd_ready", 32'(bus1.cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("reset_alu", {21'd0, a1, b1, sel1}, 32'd0);
    chk("reset_rsp", {20'd0, bus1.rsp_result, bus1.rsp_zero, bus1.rsp_carry,
        bus1.rsp_overflow, bus1.rsp_illegal, bus1.rsp_tag}, 32'd0);
    chk("reset_op_count", 32'(cnt1), 32'd0);

    issue1("add_3_4",  3'd0, 4'h3, 4'h4, 4'h5, '{4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5}, 2);
    issue1("sub_5_5",  3'd1, 4'h5, 4'h5, 4'h6, '{4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h6}, 2);
    issue1("xor_a_f",  3'd4, 4'hA, 4'hF, 4'h7, '{4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 4'h7}, 2);
    issue1("ill_110",  3'd6, 4'h9, 4'h9, 4'h3, '{4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3}, 1);
    issue1("add_9_8",  3'd0, 4'h9, 4'h8, 4'h9, '{4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h9}, 2);
    issue1("sub_2_3",  3'd1, 4'h2, 4'h3, 4'hA, '{4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA}, 2);
    issue1("ill_111",  3'd7, 4'h1, 4'h1, 4'h4, '{4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4}, 1);
    issue1("or_5_a",   3'd3, 4'h5, 4'hA, 4'hB, '{4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'hB}, 2);

    // Backpressure: response must hold while rsp_ready is low
    bus1.rsp_ready = 1'b0;
    issue1("and_bp", 3'd2, 4'hC, 4'hA, 4'h8, '{4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8}, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", 32'(bus1.rsp_valid), 32'd1);
      chk("bp_rsp_result", 32'(bus1.rsp_result), 32'h8);
      chk("bp_cmd_ready", 32'(bus1.cmd_ready), 32'd0);
      chk("bp_op_count", 32'(cnt1), 32'(exp_cnt1));
    end
    bus1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_cnt1 = exp_cnt1 + 1'b1;
    chk("bp_release_op_count", 32'(cnt1), 32'(exp_cnt1));
    chk("bp_release_cmd_ready", 32'(bus1.cmd_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_count_once", 32'(cnt1), 32'(exp_cnt1));

    // Reset while in DRIVE: command is dropped, no response
    bus1.cmd_valid = 1'b1; bus1.cmd_op = 3'd0; bus1.cmd_a = 4'h6; bus1.cmd_b = 4'h1;
    bus1.cmd_tag = 4'hE;
    @(posedge clk); #1;
    bus1.cmd_valid = 1'b0;
    chk("rstdrv_in_drive", 32'(bus1.cmd_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstdrv_cmd_ready", 32'(bus1.cmd_ready), 32'd1);
    chk("rstdrv_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("rstdrv_alu", {21'd0, a1, b1, sel1}, 32'd0);
    chk("rstdrv_rsp", {20'd0, bus1.rsp_result, bus1.rsp_zero, bus1.rsp_carry,
        bus1.rsp_overflow, bus1.rsp_illegal, bus1.rsp_tag}, 32'd0);
    chk("rstdrv_op_count", 32'(cnt1), 32'd0);
    q2.delete();
    repeat (4) begin
      @(posedge clk); #1;
      chk("rstdrv_no_rsp", 32'(bus1.rsp_valid), 32'd0);
    end
    exp_cnt1 = '0; prev_a = '0; prev_b = '0; prev_sel = '0;

    // Settle window of 4 with ALU outputs corrupted in DRIVE cycles 1-3
    q2.push_back('{4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 4'hC});
    bus2.cmd_valid = 1'b1; bus2.cmd_op = 3'd3; bus2.cmd_a = 4'h1; bus2.cmd_b = 4'h2;
    bus2.cmd_tag = 4'hC;
    guard = 0;
    while (!bus2.cmd_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    chk("s4_ready", 32'(bus2.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bus2.cmd_valid = 1'b0; bus2.cmd_a = 4'hF; bus2.cmd_op = 3'd0;
    perturb2 = 1'b1;
    lat = 1;
    while (!bus2.rsp_valid && lat < 50) begin
      if (lat == 4) perturb2 = 1'b0;
      chk("s4_drive_alu", {21'd0, a2, b2, sel2}, {21'd0, 4'h1, 4'h2, 3'd3});
      @(posedge clk); #1; lat++;
    end
    perturb2 = 1'b0;
    chk("s4_latency", 32'(lat), 32'd5);
    chk("s4_rsp_result", 32'(bus2.rsp_result), 32'h3);
    @(posedge clk); #1;
    chk("s4_op_count", 32'(cnt2), 32'd1);

    q2.push_back('{4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2});
    bus2.cmd_valid = 1'b1; bus2.cmd_op = 3'd0; bus2.cmd_a = 4'h9; bus2.cmd_b = 4'h8;
    bus2.cmd_tag = 4'h2;
    @(posedge clk); #1;
    bus2.cmd_valid = 1'b0;
    lat = 1;
    while (!bus2.rsp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk("s4_add_latency", 32'(lat), 32'd5);
    @(posedge clk); #1;
    chk("s4_op_count2", 32'(cnt2), 32'd2);

    // op_count wrap after 256 handshaked operations
    for (int i = 0; i < 256; i++) begin
      logic [3:0] va;
      va = i[3:0];
      issue1("wrap", 3'd0, va, 4'h0, i[7:4],
             '{va, (va == 4'h0), 1'b0, 1'b0, 1'b0, i[7:4]}, 2);
      if (i == 254) chk("wrap_count_255", 32'(cnt1), 32'd255);
    end
    chk("wrap_count_zero", 32'(cnt1), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
